// File: rtl/accel_filter_hub.sv
// accel_filter_hub: multi-channel accelerometer conditioner.
// Samples NUM_CH signed channels every SAMPLE_DIV enabled clocks. Each
// channel keeps a 2^AVG_LOG2-deep moving-average window and applies a
// deadzone. Results are published as sign-extended 32-bit words behind a
// data_ready/rd_ack handshake with a saturating overrun counter.
//
// Handshake: data_ready is high while an unread result sits in filt_out.
// The CPU pulses rd_ack for one or more cycles to consume it. A new load
// always wins: it refreshes filt_out and keeps data_ready high. When a load
// lands on a cycle where data_ready is high and rd_ack is low, overrun_cnt
// counts the lost result, saturating at 255.
module accel_filter_hub #(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 9,
  parameter int AVG_LOG2   = 3,
  parameter int DEADZONE   = 4,
  parameter int SAMPLE_DIV = 50000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_CH*SAMPLE_W-1:0] raw_in,
  input  logic                       rd_ack,
  output logic [NUM_CH*32-1:0]       filt_out,
  output logic                       data_ready,
  output logic                       primed,
  output logic [7:0]                 overrun_cnt
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = SAMPLE_W + AVG_LOG2;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic signed [31:0] DZ_POS   = DEADZONE;
  localparam logic signed [31:0] DZ_NEG   = -DEADZONE;

  logic [DIV_W-1:0]           div_q;
  logic                       tick;
  logic [AVG_LOG2-1:0]        ptr_q;
  logic [FILL_W-1:0]          fill_q;
  logic                       s1_vld_q;
  logic signed [SAMPLE_W-1:0] buf_q   [NUM_CH][DEPTH];
  logic signed [SUM_W-1:0]    sum_q   [NUM_CH];
  logic signed [SUM_W-1:0]    sum_d   [NUM_CH];
  logic signed [SAMPLE_W-1:0] raw_s   [NUM_CH];
  logic signed [SUM_W-1:0]    avg_s   [NUM_CH];
  logic signed [31:0]         avg_ext [NUM_CH];
  logic [NUM_CH*32-1:0]       filt_d;
  logic [NUM_CH*32-1:0]       filt_q;
  logic                       ready_q;
  logic                       primed_q;
  logic [7:0]                 ovr_q;
  logic                       load;

  assign tick = en && (div_q == DIV_LAST);

  // Sample-rate divider: advances only while enabled, wraps on the tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (en) begin
      if (div_q == DIV_LAST) div_q <= '0;
      else                   div_q <= div_q + 1'b1;
    end
  end

  // Running-sum update: add the new sample, drop the one it replaces.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      raw_s[k] = $signed(raw_in[k*SAMPLE_W +: SAMPLE_W]);
      sum_d[k] = sum_q[k]
               + {{AVG_LOG2{raw_s[k][SAMPLE_W-1]}}, raw_s[k]}
               - {{AVG_LOG2{buf_q[k][ptr_q][SAMPLE_W-1]}}, buf_q[k][ptr_q]};
    end
  end

  // Stage 1: window write, sum update, pointer/fill advance on each tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      fill_q   <= '0;
      s1_vld_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        sum_q[k] <= '0;
        for (int i = 0; i < DEPTH; i++) buf_q[k][i] <= '0;
      end
    end else begin
      s1_vld_q <= tick;
      if (tick) begin
        ptr_q <= ptr_q + 1'b1;
        if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          sum_q[k]        <= sum_d[k];
          buf_q[k][ptr_q] <= raw_s[k];
        end
      end
    end
  end

  // Stage 2 datapath: floor-average by arithmetic shift, then deadzone.
  always_comb begin
    filt_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      avg_s[k]   = sum_q[k] >>> AVG_LOG2;
      avg_ext[k] = {{(32-SUM_W){avg_s[k][SUM_W-1]}}, avg_s[k]};
      if ((avg_ext[k] > DZ_POS) || (avg_ext[k] < DZ_NEG))
        filt_d[k*32 +: 32] = avg_ext[k];
    end
  end

  // A stage-2 load happens one cycle after a tick once the window is full.
  assign load = s1_vld_q && (fill_q == FILL_FULL);

  // Stage 2 output register, handshake and overrun accounting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q   <= '0;
      ready_q  <= 1'b0;
      primed_q <= 1'b0;
      ovr_q    <= '0;
    end else if (load) begin
      filt_q   <= filt_d;
      ready_q  <= 1'b1;
      primed_q <= 1'b1;
      if (ready_q && !rd_ack && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 1'b1;
    end else if (rd_ack && ready_q) begin
      ready_q <= 1'b0;
    end
  end

  assign filt_out    = filt_q;
  assign data_ready  = ready_q;
  assign primed      = primed_q;
  assign overrun_cnt = ovr_q;

endmodule
